// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM memory controller between two requesters.
// One 8-bit access is accepted per cycle over REQ/GNT. Arbitration is
// round-robin, and a requester can hold a bus lock across an atomic sequence.
// Each accepted access is registered onto the controller command outputs.
// Read data returns to the requester that issued the read after a fixed latency.
//
// Parameters
//   RD_LAT    cycles from command on ADDR/CE/... to RDATA valid (1..6)
// Ports
//   CLK, RST                       clock, async active-high reset
//   Rn_REQ/WE/ADDR/WDATA/LOCK      requester n access request and fields
//   Rn_GNT                         combinational grant; transfer = REQ & GNT
//   Rn_RVALID/Rn_RDATA             one-cycle read strobe / held read data
//   ADDR, CE, CSB, WEB, OEB, IDATA registered controller command
//   RDATA                          read data from controller bank mux
module mem_arbiter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        R0_REQ,
  input  logic        R0_WE,
  input  logic [15:0] R0_ADDR,
  input  logic [7:0]  R0_WDATA,
  input  logic        R0_LOCK,
  output logic        R0_GNT,
  output logic        R0_RVALID,
  output logic [7:0]  R0_RDATA,
  input  logic        R1_REQ,
  input  logic        R1_WE,
  input  logic [15:0] R1_ADDR,
  input  logic [7:0]  R1_WDATA,
  input  logic        R1_LOCK,
  output logic        R1_GNT,
  output logic        R1_RVALID,
  output logic [7:0]  R1_RDATA,
  output logic [15:0] ADDR,
  output logic        CE,
  output logic        CSB,
  output logic        WEB,
  output logic        OEB,
  output logic [7:0]  IDATA,
  input  logic [7:0]  RDATA
);

  logic        prio_q;
  logic        lock_valid_q;
  logic        lock_owner_q;

  logic        gnt0, gnt1;
  logic        xfer, xid;
  logic        x_we, x_lock;
  logic [15:0] x_addr;
  logic [7:0]  x_wdata;

  // Read-tag pipeline: stage 0 lines up with the command cycle, stage RD_LAT
  // with the cycle in which RDATA is valid.
  logic [RD_LAT:0] tv_q, tv_d;
  logic [RD_LAT:0] tid_q, tid_d;

  logic [15:0] addr_q;
  logic        ce_q, csb_q, web_q, oeb_q;
  logic [7:0]  idata_q;
  logic        rvalid0_q, rvalid1_q;
  logic [7:0]  rdata0_q, rdata1_q;

  // Grants are forced low while reset is held so the outputs read as reset
  // values even with a request pending.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
      if (lock_valid_q) begin
        gnt0 = R0_REQ & ~lock_owner_q;
        gnt1 = R1_REQ &  lock_owner_q;
      end else if (R0_REQ && R1_REQ) begin
        gnt0 = ~prio_q;
        gnt1 =  prio_q;
      end else begin
        gnt0 = R0_REQ;
        gnt1 = R1_REQ;
      end
    end
  end

  assign R0_GNT = gnt0;
  assign R1_GNT = gnt1;

  always_comb begin
    xfer    = (R0_REQ & gnt0) | (R1_REQ & gnt1);
    xid     = R1_REQ & gnt1;
    x_we    = xid ? R1_WE    : R0_WE;
    x_lock  = xid ? R1_LOCK  : R0_LOCK;
    x_addr  = xid ? R1_ADDR  : R0_ADDR;
    x_wdata = xid ? R1_WDATA : R0_WDATA;
    tv_d    = {tv_q[RD_LAT-1:0],  xfer & ~x_we};
    tid_d   = {tid_q[RD_LAT-1:0], xid};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio_q       <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      tv_q         <= '0;
      tid_q        <= '0;
      addr_q       <= '0;
      ce_q         <= 1'b0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      oeb_q        <= 1'b1;
      idata_q      <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      tv_q  <= tv_d;
      tid_q <= tid_d;
      if (xfer) begin
        prio_q       <= ~xid;
        // Only the owner can transfer while locked, so loading LOCK here
        // both takes and releases the lock.
        lock_valid_q <= x_lock;
        lock_owner_q <= xid;
        addr_q       <= x_addr;
        idata_q      <= x_wdata;
        ce_q         <= 1'b1;
        csb_q        <= 1'b0;
        web_q        <= ~x_we;
        oeb_q        <= x_we;
      end else begin
        ce_q  <= 1'b0;
        csb_q <= 1'b1;
        web_q <= 1'b1;
        oeb_q <= 1'b1;
      end
      rvalid0_q <= tv_q[RD_LAT] & ~tid_q[RD_LAT];
      rvalid1_q <= tv_q[RD_LAT] &  tid_q[RD_LAT];
      if (tv_q[RD_LAT] && !tid_q[RD_LAT]) rdata0_q <= RDATA;
      if (tv_q[RD_LAT] &&  tid_q[RD_LAT]) rdata1_q <= RDATA;
    end
  end

  assign ADDR      = addr_q;
  assign CE        = ce_q;
  assign CSB       = csb_q;
  assign WEB       = web_q;
  assign OEB       = oeb_q;
  assign IDATA     = idata_q;
  assign R0_RVALID = rvalid0_q;
  assign R1_RVALID = rvalid1_q;
  assign R0_RDATA  = rdata0_q;
  assign R1_RDATA  = rdata1_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the 64-bank SRAM memory controller between two requesters (e.g. core and DMA). It accepts one 8-bit read or write per cycle through a REQ/GNT handshake, using round-robin priority with an optional bus lock for atomic sequences. Each accepted access is driven as a registered command onto the controller's command inputs. Read data is returned to the issuing requester after a fixed, parameterised latency.

## Interface
- RD_LAT, 2, cycles from a command being driven on the controller outputs to RDATA being valid at the input (controller register + SRAM access); legal 1..6

- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- R0_REQ / R1_REQ  in  1  access request
- R0_WE / R1_WE  in  1  1 = write, 0 = read
- R0_ADDR / R1_ADDR  in  16  byte address; [15:10] bank, [9:0] word
- R0_WDATA / R1_WDATA  in  8  write data
- R0_LOCK / R1_LOCK  in  1  keep ownership after this transfer
- R0_GNT / R1_GNT  out  1  combinational; transfer occurs when REQ & GNT
- R0_RVALID / R1_RVALID  out  1  one-cycle read-data strobe
- R0_RDATA / R1_RDATA  out  8  read data, held until next RVALID
- ADDR  out  16  to controller
- CE  out  1  access enable, active high
- CSB  out  1  chip select, active low
- WEB  out  1  write enable, active low
- OEB  out  1  output enable, active low (low for reads only)
- IDATA  out  8  write data to controller
- RDATA  in  8  read data from controller bank mux

## Operation
- State: prio pointer (0/1), lock_valid, lock_owner, read-tag pipeline of RD_LAT+1 stages {valid, id}.
- Grant, unlocked: only one REQ high -> grant it. Both high -> grant requester named by prio. Neither high -> no grant.
- On each transfer by n: prio <= ~n.
- Lock: a transfer with LOCK=1 sets lock_valid=1, lock_owner=n. While locked, only lock_owner can be granted. The other requester is held off even when the owner is idle. A transfer by the owner with LOCK=0 clears lock_valid at the same edge. prio is still updated on every transfer.
- Command register, on a transfer: ADDR<=addr, CE<=1, CSB<=0, WEB<=~WE, OEB<=WE, IDATA<=WDATA.
- Command register, no transfer: CE<=0, CSB<=1, WEB<=1, OEB<=1. ADDR and IDATA hold their previous values.
- Read tagging: a read transfer pushes {1, n} into stage 0; writes push {0, x}. The pipeline shifts every cycle.
- At the output stage, Rn_RVALID<=1 and Rn_RDATA<=RDATA for the tagged requester. The other requester's RDATA holds.
- Writes produce no response.
- Max one transfer per cycle; back-to-back transfers are allowed with no bubble.

## Timing
- Transfer in cycle t: controller command outputs valid in cycle t+1.
- RDATA sampled at the end of cycle t+1+RD_LAT; Rn_RVALID/Rn_RDATA valid in cycle t+2+RD_LAT (t+4 at default).
- Read responses return in issue order, one per cycle max, and may interleave between requesters.
- GNT depends only on REQ, prio and lock state. GNT is independent of WE, ADDR and LOCK.
- Reset (async, any time):
  - GNT=0, RVALID=0, RDATA=0.
  - ADDR=0, CE=0, CSB=1, WEB=1, OEB=1, IDATA=0.
  - prio=0, lock cleared, tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and no RVALID is issued after deassertion. The first cycle after release is arbitrated normally.
- Simultaneous lock release by the owner and REQ from the other requester: the other requester can be granted the following cycle, not the same cycle.
- The requester keeps REQ and its fields stable until GNT. Dropping REQ before GNT is legal and cancels the request.

## Test plan
- Reset then single read: R0 read 0x0C05 at t, RDATA=0x5A in t+3 -> CE=1, CSB=0, OEB=0, WEB=1, ADDR=0x0C05 in t+1; R0_RVALID=1, R0_RDATA=0x5A in t+4; R1_RVALID stays 0.
- Contention: R0 and R1 both REQ continuously for 6 cycles -> grants alternate R0,R1,R0,R1,R0,R1; CE=1 on six consecutive cycles.
- Lock: R1 writes 0x0400=0x11 with LOCK=1, then idles 2 cycles while R0 requests -> R0_GNT=0 throughout. R1 then reads with LOCK=0 -> R0 is granted in the next cycle.
- Interleaved reads: R0 read at t, R1 read at t+1, RDATA=0xA1 then 0xB2 -> R0_RVALID with 0xA1 in t+4, R1_RVALID with 0xB2 in t+5.
- Write path: R1 writes 0xFFFF=0x3C -> in the next cycle WEB=0, OEB=1, CSB=0, IDATA=0x3C, ADDR=0xFFFF; no RVALID follows.
- Reset mid-read: R0 read at t, RST pulse in t+2 -> all outputs at reset values immediately; no R0_RVALID in t+4.
